dm_arbiter: RTL and testbench
=============================

Name: dm_arbiter

Overview:
- Two-master arbiter and sequencer for the single-ported, word-organised data memory.
- Master 0 is the CPU MEM-stage data port. Master 1 is a secondary requester (loader/DMA/debug).
- Serialises accesses with round-robin priority and performs sub-word stores as read-modify-write on the word port.
- Returns registered read data with a one-cycle ack pulse.

Parameters:
- ADDR_W, 10, word-index width; memory holds 2^ADDR_W words; byte addresses are masked to [ADDR_W+1:2].
- RR_INIT, 0, master given priority after reset (0 or 1).

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- m0_req  in  1  master 0 request; held high until m0_ack
- m0_we  in  1  master 0 write (1) / read (0)
- m0_be  in  4  master 0 byte enables; be[i] covers wdata[8i+7:8i]
- m0_addr  in  32  master 0 byte address; bits [1:0] ignored
- m0_wdata  in  32  master 0 write data, lane-aligned
- m0_rdata  out  32  master 0 read data, valid while m0_ack=1
- m0_ack  out  1  one-cycle completion pulse
- m1_req, m1_we, m1_be, m1_addr, m1_wdata, m1_rdata, m1_ack: same as master 0, for master 1
- mem_addr  out  32  word-aligned byte address to memory; {zeros, addr[ADDR_W+1:2], 2'b00}
- mem_we  out  1  whole-word write strobe, sampled by memory at posedge
- mem_wdata  out  32  merged word to write
- mem_rdata  in  32  memory read data, combinational from mem_addr
- busy  out  1  high when state is not IDLE

Behaviour:
- Clocking and reset: one clock (clk); reset is synchronous, active-high.
- Reset values:
  - state=IDLE; ack outputs 0; rdata outputs 0; busy 0.
  - Priority pointer = RR_INIT; latched request fields cleared.
- mem_we is gated by !reset in the same cycle. Reset asserted while in SERVE produces no memory write and no ack.
- State machine IDLE -> SERVE -> RESP -> IDLE:
  - IDLE: if no req, stay. If exactly one req, grant it. If both, grant the master named by the pointer. Latch we/be/addr/wdata and the master id, then go to SERVE.
  - SERVE:
    - mem_addr = latched address.
    - Read: capture mem_rdata into the granted master's rdata register.
    - Write, be=4'hF: mem_wdata = wdata; mem_we=1.
    - Write, partial be: mem_wdata byte i = be[i] ? wdata byte i : mem_rdata byte i; mem_we=1.
    - Write, be=4'h0: mem_we=0; the access still completes.
    - Write rdata register = the merged word (pre-write memory contents are not returned).
    - Go to RESP.
  - RESP: granted master's ack=1 for exactly this cycle. Pointer flips to the other master. Go to IDLE.
- Outside SERVE, mem_we=0 and mem_addr holds the last latched address.
- Latency and throughput:
  - Request seen in IDLE at cycle N: memory access in cycle N+1, ack in cycle N+2.
  - A request still high after its ack is treated as a new request in the following IDLE cycle.
  - Maximum throughput is 1 access per 3 cycles.
- Requests and masters:
  - Inputs are sampled only in IDLE. Changes to the request fields after grant are ignored.
  - A req dropped before grant is never served.
  - The non-granted master's ack stays 0 and its rdata register holds its previous value.
- Fairness: with both masters continuously requesting, grants strictly alternate. No master waits more than one other access.
- Address wrap: bits above ADDR_W+1 are discarded, so addresses alias modulo 4*2^ADDR_W.

Test Plan:
- Reset, then m0 read of 0x0000_0010 with mem word = 0x1234_5678 -> mem_we=0 throughout; m0_ack in cycle 2 after req; m0_rdata=0x1234_5678; m1_ack=0.
- m0 write, be=4'hF, addr 0x20, wdata 0xDEAD_BEEF -> exactly one mem_we pulse, mem_addr=0x20, mem_wdata=0xDEAD_BEEF; a following read returns 0xDEAD_BEEF.
- Mem[0x20]=0xDEAD_BEEF, m1 write be=4'b0010, wdata 0x0000_5500 -> mem_wdata=0xDEAD_55EF, m1_ack once, m1_rdata=0xDEAD_55EF.
- m0_req and m1_req both held high for 4 accesses after reset, RR_INIT=0 -> grant order 0,1,0,1; acks 3 cycles apart; each ack a one-cycle pulse.
- Write with be=4'h0 -> no mem_we, ack still issued. Reset asserted in SERVE of a be=4'hF write -> memory unchanged, no ack, busy=0 next cycle.
- m0 read of addr 0x0000_1004 with ADDR_W=10 -> mem_addr=0x0000_0004; data of word 1 returned.

Source files
------------

// File: rtl/dm_arbiter.sv
// Two-master round-robin arbiter/sequencer for a single-ported word memory.
// Sub-word stores are done as read-modify-write within one SERVE cycle.
module dm_arbiter #(
  parameter int unsigned ADDR_W  = 10,
  parameter bit          RR_INIT = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [3:0]  m0_be,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic [31:0] m0_rdata,
  output logic        m0_ack,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [3:0]  m1_be,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic [31:0] m1_rdata,
  output logic        m1_ack,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  typedef enum logic [1:0] {StIdle, StServe, StResp} state_e;

  state_e            state_q, state_d;
  logic              ptr_q, ptr_d;
  logic              id_q, id_d;
  logic              we_q, we_d;
  logic [3:0]        be_q, be_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata0_q, rdata0_d;
  logic [31:0]       rdata1_q, rdata1_d;
  logic [31:0]       merged;
  logic [31:0]       rword;
  logic              gnt;

  always_comb begin
    for (int b = 0; b < 4; b++) begin
      merged[8*b +: 8] = be_q[b] ? wdata_q[8*b +: 8] : mem_rdata[8*b +: 8];
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    id_d     = id_q;
    we_d     = we_q;
    be_d     = be_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    gnt      = 1'b0;
    rword    = mem_rdata;
    mem_we   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (m0_req || m1_req) begin
          // Contention resolved by the pointer; a lone requester always wins.
          gnt     = (m0_req && m1_req) ? ptr_q : m1_req;
          id_d    = gnt;
          we_d    = gnt ? m1_we : m0_we;
          be_d    = gnt ? m1_be : m0_be;
          addr_d  = gnt ? m1_addr[ADDR_W+1:2] : m0_addr[ADDR_W+1:2];
          wdata_d = gnt ? m1_wdata : m0_wdata;
          state_d = StServe;
        end
      end
      StServe: begin
        rword = we_q ? merged : mem_rdata;
        if (id_q) rdata1_d = rword;
        else      rdata0_d = rword;
        mem_we  = we_q && (be_q != 4'h0) && !reset;
        state_d = StResp;
      end
      StResp: begin
        ptr_d   = ~id_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      ptr_q    <= RR_INIT;
      id_q     <= 1'b0;
      we_q     <= 1'b0;
      be_q     <= 4'h0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      id_q     <= id_d;
      we_q     <= we_d;
      be_q     <= be_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  always_comb begin
    mem_addr                = '0;
    mem_addr[ADDR_W+1:2]    = addr_q;
  end

  assign mem_wdata = merged;
  assign m0_rdata  = rdata0_q;
  assign m1_rdata  = rdata1_q;
  assign m0_ack    = (state_q == StResp) && !id_q;
  assign m1_ack    = (state_q == StResp) && id_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_dm_arbiter.sv
// Scoreboard bench for dm_arbiter: a transaction-level model predicts acks and
// memory writes in service order; a negedge monitor compares against the DUT.
module tb_dm_arbiter;
  localparam int unsigned AW = 10;

  typedef struct {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  typedef struct {
    bit          id;
    logic [31:0] rdata;
    logic [31:0] other;
    int          cyc;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0;
  logic [3:0]  m0_be = 0, m1_be = 0;
  logic [31:0] m0_addr = 0, m0_wdata = 0, m1_addr = 0, m1_wdata = 0;
  logic [31:0] m0_rdata, m1_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        m0_ack, m1_ack, mem_we, busy;

  logic [31:0] tb_mem  [2**AW];
  logic [31:0] ref_mem [2**AW];
  logic [31:0] model_rdata [2];
  bit          model_ptr;
  exp_t        exp_q[$];
  wr_t         wr_q[$];
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;

  dm_arbiter #(.ADDR_W(AW), .RR_INIT(1'b0)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_be(m0_be), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_rdata(m0_rdata), .m0_ack(m0_ack),
    .m1_req(m1_req), .m1_we(m1_we), .m1_be(m1_be), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_rdata(m1_rdata), .m1_ack(m1_ack),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  assign mem_rdata = tb_mem[mem_addr[AW+1:2]];
  always @(posedge clk) if (mem_we) tb_mem[mem_addr[AW+1:2]] <= mem_wdata;

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%h required=%h", name, act, req);
    end
  endtask

  // Reference: spec rules applied to a flat word array, in service order.
  task automatic predict(bit id, txn_t t, int ack_cyc);
    int unsigned idx;
    logic [31:0] r;
    exp_t e;
    wr_t w;
    idx = int'(t.addr[AW+1:2]);
    r = ref_mem[idx];
    if (t.we) begin
      for (int b = 0; b < 4; b++) if (t.be[b]) r[8*b +: 8] = t.wdata[8*b +: 8];
      if (t.be != 4'h0) begin
        w.addr = idx * 4;
        w.data = r;
        wr_q.push_back(w);
        ref_mem[idx] = r;
      end
    end
    e.id = id;
    e.rdata = r;
    e.other = model_rdata[!id];
    e.cyc = ack_cyc;
    exp_q.push_back(e);
    model_rdata[id] = r;
    model_ptr = !id;
  endtask

  task automatic check_ack(bit id);
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++; failures++;
      $display("FAIL unexpected_ack: actual=m%0d ack required=none", id);
    end else begin
      e = exp_q.pop_front();
      chk("ack_master", 32'(id), 32'(e.id));
      chk("ack_cycle", 32'(cyc), 32'(e.cyc));
      chk(id ? "m1_rdata" : "m0_rdata", id ? m1_rdata : m0_rdata, e.rdata);
      chk(id ? "m0_rdata_hold" : "m1_rdata_hold", id ? m0_rdata : m1_rdata, e.other);
    end
  endtask

  always @(negedge clk) begin
    wr_t w;
    if (m0_ack && m1_ack) begin
      checks++; failures++;
      $display("FAIL dual_ack: actual=both required=one");
    end
    if (m0_ack) check_ack(1'b0);
    if (m1_ack) check_ack(1'b1);
    if (mem_we) begin
      if (wr_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_mem_we: actual=write@%h required=none", mem_addr);
      end else begin
        w = wr_q.pop_front();
        chk("mem_addr", mem_addr, w.addr);
        chk("mem_wdata", mem_wdata, w.data);
      end
    end
  end

  function automatic txn_t rand_txn();
    txn_t t;
    int unsigned k;
    t.we = 1'($urandom_range(0, 1));
    k = $urandom_range(0, 5);
    t.be = (k == 0) ? 4'h0 : (k < 3) ? 4'hF : 4'($urandom);
    t.addr = ($urandom & 32'hFFFF_F000) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
    t.wdata = $urandom;
    return t;
  endfunction

  task automatic drive_wait(bit id, bit scr);
    bit got = 0;
    if (scr) begin
      @(posedge clk); #1;
      if (id) begin m1_we = ~m1_we; m1_be = ~m1_be; m1_addr = $urandom; m1_wdata = $urandom; end
      else    begin m0_we = ~m0_we; m0_be = ~m0_be; m0_addr = $urandom; m0_wdata = $urandom; end
    end
    for (int i = 0; i < 12 && !got; i++) begin
      @(negedge clk);
      got = id ? m1_ack : m0_ack;
    end
    if (!got) begin
      checks++; failures++;
      $display("FAIL ack_timeout: actual=no ack m%0d required=ack", id);
    end
    if (id) m1_req = 0; else m0_req = 0;
  endtask

  // en: bit0 = m0 requests, bit1 = m1 requests; both raised in the same IDLE cycle.
  task automatic issue(bit [1:0] en, txn_t t0, txn_t t1, bit scr);
    bit first;
    @(posedge clk); #1;
    {m0_we, m0_be, m0_addr, m0_wdata} = {t0.we, t0.be, t0.addr, t0.wdata};
    {m1_we, m1_be, m1_addr, m1_wdata} = {t1.we, t1.be, t1.addr, t1.wdata};
    if (en == 2'b11) begin
      first = model_ptr;
      predict(first, first ? t1 : t0, cyc + 2);
      predict(!first, first ? t0 : t1, cyc + 5);
    end else if (en[0]) predict(1'b0, t0, cyc + 2);
    else                predict(1'b1, t1, cyc + 2);
    m0_req = en[0];
    m1_req = en[1];
    fork
      if (en[0]) drive_wait(1'b0, scr && en != 2'b11);
      if (en[1]) drive_wait(1'b1, scr && en != 2'b11);
    join
  endtask

  function automatic txn_t mk(logic we, logic [3:0] be, logic [31:0] a, logic [31:0] d);
    txn_t t;
    t.we = we; t.be = be; t.addr = a; t.wdata = d;
    return t;
  endfunction

  initial begin
    txn_t nul, t;
    logic [31:0] v;
    nul = mk(1'b0, 4'h0, 32'h0, 32'h0);
    for (int i = 0; i < 2**AW; i++) begin
      v = $urandom;
      tb_mem[i] = v;
      ref_mem[i] = v;
    end
    tb_mem[4] = 32'h1234_5678; ref_mem[4] = 32'h1234_5678;
    tb_mem[1] = 32'hCAFE_0001; ref_mem[1] = 32'hCAFE_0001;
    model_rdata[0] = 0; model_rdata[1] = 0; model_ptr = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_m0_ack", 32'(m0_ack), 0);
    chk("rst_m1_ack", 32'(m1_ack), 0);
    chk("rst_m0_rdata", m0_rdata, 0);
    chk("rst_m1_rdata", m1_rdata, 0);

    // Both held for four accesses from reset: expect grants 0,1,0,1.
    issue(2'b11, mk(1'b0, 4'hF, 32'h8, 0), mk(1'b0, 4'hF, 32'hC, 0), 0);
    issue(2'b11, mk(1'b0, 4'hF, 32'h18, 0), mk(1'b0, 4'hF, 32'h1C, 0), 0);

    issue(2'b01, mk(1'b0, 4'hF, 32'h10, 0), nul, 1);
    issue(2'b01, mk(1'b1, 4'hF, 32'h20, 32'hDEAD_BEEF), nul, 1);
    issue(2'b01, mk(1'b0, 4'hF, 32'h20, 0), nul, 0);
    issue(2'b10, nul, mk(1'b1, 4'b0010, 32'h20, 32'h0000_5500), 0);
    chk("rmw_word", tb_mem[8], 32'hDEAD_55EF);
    issue(2'b01, mk(1'b1, 4'h0, 32'h24, 32'h1111_1111), nul, 0);
    issue(2'b01, mk(1'b0, 4'hF, 32'h0000_1004, 0), nul, 0);

    // m1 pulses req only while m0 is being served: must never be granted.
    @(posedge clk); #1;
    m0_we = 0; m0_addr = 32'h30; m0_req = 1;
    predict(1'b0, mk(1'b0, 4'hF, 32'h30, 0), cyc + 2);
    @(posedge clk); #1 m1_req = 1; m1_we = 0;
    @(posedge clk); #1 m1_req = 0;
    @(negedge clk); m0_req = 0;
    repeat (4) @(posedge clk);

    // Reset during SERVE of a full-word write: no write, no ack.
    @(posedge clk); #1;
    m0_we = 1; m0_be = 4'hF; m0_addr = 32'h40; m0_wdata = ~ref_mem[16]; m0_req = 1;
    @(posedge clk); #1 reset = 1; m0_req = 0;
    @(posedge clk); #1;
    chk("rst_serve_busy", 32'(busy), 0);
    chk("rst_serve_ack", 32'(m0_ack), 0);
    chk("rst_serve_mem", tb_mem[16], ref_mem[16]);
    chk("rst_serve_rdata", m0_rdata, 0);
    reset = 0;
    model_ptr = 1'b0; model_rdata[0] = 0; model_rdata[1] = 0;

    for (int r = 0; r < 60; r++) begin
      t = rand_txn();
      issue(2'($urandom_range(1, 3)), t, rand_txn(), 1'($urandom_range(0, 1)));
    end

    repeat (4) @(posedge clk);
    chk("exp_q_drained", 32'(exp_q.size()), 0);
    chk("wr_q_drained", 32'(wr_q.size()), 0);
    for (int i = 0; i < 16; i++) chk("final_mem", tb_mem[i], ref_mem[i]);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: actual=running required=finished");
    $fatal(1);
  end
endmodule
